// File: rtl/map_req_arbiter.sv
// Round-robin arbiter sharing one world-map BRAM read port among NUM_REQ requesters.
// Optional MAP_ARB_STATS_EN adds a saturating 16-bit contention counter.
module map_req_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned N            = 24,
  parameter int unsigned MAP_W        = 5,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  input  logic [NUM_REQ-1:0]                req_in,
  input  logic [NUM_REQ*$clog2(N*N)-1:0]    addr_in,
  output logic [NUM_REQ-1:0]                ack_out,
  output logic [$clog2(N*N)-1:0]            map_addra_out,
  input  logic [MAP_W-1:0]                  map_data_in,
  output logic [MAP_W-1:0]                  data_out,
  output logic [NUM_REQ-1:0]                data_valid_out,
  output logic                              busy_out,
  output logic [15:0]                       conflict_count_out
);

  localparam int unsigned AW = $clog2(N*N);
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NS = READ_LATENCY + 1;

  logic [AW-1:0]      addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] dv_q, dv_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win;
  logic               grant;
  logic [AW-1:0]      addr_q;
  logic [MAP_W-1:0]   data_q;
  logic [NS-1:0]      tag_v_q;
  logic [PW-1:0]      tag_own_q [NS];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr_in[g*AW +: AW];
  end

  assign elig = req_in & ~pending_q;

  // First eligible requester at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    grant = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant && elig[PW'(idx)]) begin
        grant = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    ack_d     = '0;
    dv_d      = '0;
    ptr_d     = ptr_q;
    if (tag_v_q[NS-1]) begin
      pending_d[tag_own_q[NS-1]] = 1'b0;
      dv_d[tag_own_q[NS-1]]      = 1'b1;
    end
    if (grant) begin
      pending_d[win] = 1'b1;
      ack_d[win]     = 1'b1;
      ptr_d          = (32'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pending_q <= '0;
      ack_q     <= '0;
      dv_q      <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tag_v_q   <= '0;
      for (int unsigned j = 0; j < NS; j++) tag_own_q[j] <= '0;
    end else begin
      pending_q <= pending_d;
      ack_q     <= ack_d;
      dv_q      <= dv_d;
      ptr_q     <= ptr_d;
      if (grant) addr_q <= addr_arr[win];
      if (tag_v_q[NS-1]) data_q <= map_data_in;
      // Tag pipeline advances unconditionally to match the fixed BRAM latency.
      tag_v_q      <= {tag_v_q[NS-2:0], grant};
      tag_own_q[0] <= win;
      for (int unsigned j = 1; j < NS; j++) tag_own_q[j] <= tag_own_q[j-1];
    end
  end

`ifdef MAP_ARB_STATS_EN
  logic [15:0] conflict_q;
  logic        multi;

  assign multi = ($countones(elig) > 1);

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      conflict_q <= '0;
    end else if (multi && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_count_out = conflict_q;
`else
  assign conflict_count_out = 16'd0;
`endif

  assign ack_out        = ack_q;
  assign data_valid_out = dv_q;
  assign map_addra_out  = addr_q;
  assign data_out       = data_q;
  assign busy_out       = |tag_v_q;

endmodule

// File: tb/tb_map_req_arbiter.sv
// Self-checking bench for map_req_arbiter with a latency-2 BRAM model.
module tb_map_req_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned MW = 5;
  localparam int unsigned RL = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_in = '0;
  logic [NR*AW-1:0] addr_in;
  logic [NR-1:0]  ack_out;
  logic [AW-1:0]  map_addra_out;
  logic [MW-1:0]  map_data_in;
  logic [MW-1:0]  data_out;
  logic [NR-1:0]  data_valid_out;
  logic           busy_out;
  logic [15:0]    conflict_count_out;

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  map_req_arbiter #(.NUM_REQ(NR), .N(24), .MAP_W(MW), .READ_LATENCY(RL)) u_dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst_n),
    .req_in             (req_in),
    .addr_in            (addr_in),
    .ack_out            (ack_out),
    .map_addra_out      (map_addra_out),
    .map_data_in        (map_data_in),
    .data_out           (data_out),
    .data_valid_out     (data_valid_out),
    .busy_out           (busy_out),
    .conflict_count_out (conflict_count_out)
  );

  // Map contents: entry a holds a[4:0] ^ 12 (so entry 37 holds 9).
  function automatic logic [MW-1:0] map_val(input logic [AW-1:0] a);
    return a[4:0] ^ 5'd12;
  endfunction

  logic [MW-1:0] rd_pipe [RL];
  always_ff @(posedge clk) begin
    rd_pipe[0] <= map_val(map_addra_out);
    for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
  end
  assign map_data_in = rd_pipe[RL-1];

  assign addr_in = {10'd575, 10'd200, 10'd100, 10'd37};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req_in = '0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {ack_out, data_valid_out, map_addra_out, data_out, busy_out},
          32'd0);
    check("reset_conflict", 32'(conflict_count_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit            rst;
    logic [NR-1:0] req;
    logic [NR-1:0] ack;
    logic [NR-1:0] dv;
    logic [MW-1:0] data;
    logic [AW-1:0] addr;
    logic          busy;
  } vec_t;

  vec_t vecs [29];

  initial begin
    int acks;
    int outst;
    bit any_dv;

    // All four requesting continuously, then dropping.
    vecs[0]  = '{1, 4'hF, 4'b0001, 4'b0000, 5'd0,  10'd37,  1'b1};
    vecs[1]  = '{0, 4'hF, 4'b0010, 4'b0000, 5'd0,  10'd100, 1'b1};
    vecs[2]  = '{0, 4'hF, 4'b0100, 4'b0000, 5'd0,  10'd200, 1'b1};
    vecs[3]  = '{0, 4'hF, 4'b1000, 4'b0001, 5'd9,  10'd575, 1'b1};
    vecs[4]  = '{0, 4'hF, 4'b0001, 4'b0010, 5'd8,  10'd37,  1'b1};
    vecs[5]  = '{0, 4'hF, 4'b0010, 4'b0100, 5'd4,  10'd100, 1'b1};
    vecs[6]  = '{0, 4'hF, 4'b0100, 4'b1000, 5'd19, 10'd200, 1'b1};
    vecs[7]  = '{0, 4'hF, 4'b1000, 4'b0001, 5'd9,  10'd575, 1'b1};
    vecs[8]  = '{0, 4'h0, 4'b0000, 4'b0010, 5'd8,  10'd575, 1'b1};
    vecs[9]  = '{0, 4'h0, 4'b0000, 4'b0100, 5'd4,  10'd575, 1'b1};
    vecs[10] = '{0, 4'h0, 4'b0000, 4'b1000, 5'd19, 10'd575, 1'b0};
    vecs[11] = '{0, 4'h0, 4'b0000, 4'b0000, 5'd19, 10'd575, 1'b0};
    // Single request from requester 0, dropped after ack.
    vecs[12] = '{1, 4'b0001, 4'b0001, 4'b0000, 5'd0, 10'd37, 1'b1};
    vecs[13] = '{0, 4'b0000, 4'b0000, 4'b0000, 5'd0, 10'd37, 1'b1};
    vecs[14] = '{0, 4'b0000, 4'b0000, 4'b0000, 5'd0, 10'd37, 1'b1};
    vecs[15] = '{0, 4'b0000, 4'b0000, 4'b0001, 5'd9, 10'd37, 1'b0};
    vecs[16] = '{0, 4'b0000, 4'b0000, 4'b0000, 5'd9, 10'd37, 1'b0};
    // Requesters 1 and 3 continuously requesting.
    vecs[17] = '{1, 4'b1010, 4'b0010, 4'b0000, 5'd0,  10'd100, 1'b1};
    vecs[18] = '{0, 4'b1010, 4'b1000, 4'b0000, 5'd0,  10'd575, 1'b1};
    vecs[19] = '{0, 4'b1010, 4'b0000, 4'b0000, 5'd0,  10'd575, 1'b1};
    vecs[20] = '{0, 4'b1010, 4'b0000, 4'b0010, 5'd8,  10'd575, 1'b1};
    vecs[21] = '{0, 4'b1010, 4'b0010, 4'b1000, 5'd19, 10'd100, 1'b1};
    vecs[22] = '{0, 4'b1010, 4'b1000, 4'b0000, 5'd19, 10'd575, 1'b1};
    vecs[23] = '{0, 4'b1010, 4'b0000, 4'b0000, 5'd19, 10'd575, 1'b1};
    vecs[24] = '{0, 4'b1010, 4'b0000, 4'b0010, 5'd8,  10'd575, 1'b1};
    vecs[25] = '{0, 4'b1010, 4'b0010, 4'b1000, 5'd19, 10'd100, 1'b1};
    vecs[26] = '{0, 4'b0000, 4'b0000, 4'b0000, 5'd19, 10'd100, 1'b1};
    vecs[27] = '{0, 4'b0000, 4'b0000, 4'b0000, 5'd19, 10'd100, 1'b1};
    vecs[28] = '{0, 4'b0000, 4'b0000, 4'b0010, 5'd8,  10'd100, 1'b0};

    #12;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      if (vecs[i].rst) do_reset();
      req_in = vecs[i].req;
      @(posedge clk); #1;
      check($sformatf("v%0d_ack", i),  32'(ack_out),        32'(vecs[i].ack));
      check($sformatf("v%0d_dv", i),   32'(data_valid_out), 32'(vecs[i].dv));
      check($sformatf("v%0d_data", i), 32'(data_out),       32'(vecs[i].data));
      check($sformatf("v%0d_addr", i), 32'(map_addra_out),  32'(vecs[i].addr));
      check($sformatf("v%0d_busy", i), 32'(busy_out),       32'(vecs[i].busy));
`ifdef MAP_ARB_STATS_EN
      if (i == 11) check("conflict_all4", 32'(conflict_count_out), 32'd3);
      if (i == 28) check("conflict_pair", 32'(conflict_count_out), 32'd1);
`else
      if (i == 11 || i == 28) check("conflict_off", 32'(conflict_count_out), 32'd0);
`endif
    end

    // Requester 2 holds its request for 10 cycles.
    do_reset();
    req_in = 4'b0100;
    acks = 0;
    outst = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("held_ack_c%0d", k), 32'(ack_out),
            (k % 4 == 1) ? 32'h4 : 32'h0);
      if (data_valid_out != '0) outst--;
      if (ack_out != '0) begin
        outst++;
        acks++;
      end
      check($sformatf("held_outst_c%0d", k), 32'(outst > 1), 32'd0);
    end
    req_in = '0;
    check("held_ack_total", 32'(acks), 32'd3);
    repeat (6) @(posedge clk);

    // Reset while a read to requester 1 is in flight.
    do_reset();
    req_in = 4'b0010;
    @(posedge clk); #1;
    check("mid_ack", 32'(ack_out), 32'h2);
    req_in = '0;
    @(posedge clk); #1;
    check("mid_busy_pre", 32'(busy_out), 32'd1);
    check("mid_addr_pre", 32'(map_addra_out), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {ack_out, data_valid_out, map_addra_out, data_out, busy_out},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    any_dv = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (data_valid_out != '0) any_dv = 1'b1;
    end
    check("mid_no_dv_after", 32'(any_dv), 32'd0);
    check("mid_busy_after", 32'(busy_out), 32'd0);

`ifdef MAP_ARB_STATS_EN
    // Counter saturation from a preloaded value.
    do_reset();
    force u_dut.conflict_q = 16'hFFFE;
    #1;
    release u_dut.conflict_q;
    req_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("sat_conflict", 32'(conflict_count_out), 32'hFFFF);
    req_in = '0;
    repeat (6) @(posedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/map_req_arbiter.md
# map_req_arbiter

Round-robin arbiter sharing one read port of the world-map BRAM among `NUM_REQ` DDA FSM requesters. It issues one map read per cycle and tracks each in-flight read with a tag pipeline matched to the BRAM's fixed read latency. It returns each result, as a one-cycle valid pulse, only to the requester that issued it. It sits between the DDA FSM array and the top-level map BRAM, replacing per-pair ad-hoc arbitration.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `N`, 24: map side length; address width `AW = $clog2(N*N)`.
- `MAP_W`, 5: map data width.
- `READ_LATENCY`, 2: cycles from `map_addra_out` change to valid `map_data_in` (1..4).

Ports:
- `pixel_clk_in` in 1: sole clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `req_in` in `NUM_REQ`: level request per requester; held until `ack_out` bit seen.
- `addr_in` in `NUM_REQ*AW`: requester i address at bits `[i*AW +: AW]`, stable while `req_in[i]` high.
- `ack_out` out `NUM_REQ`: one-hot, one-cycle grant pulse.
- `map_addra_out` out `AW`: address to BRAM.
- `map_data_in` in `MAP_W`: BRAM read data.
- `data_out` out `MAP_W`: returned map value, shared bus.
- `data_valid_out` out `NUM_REQ`: one-hot, one-cycle; qualifies `data_out` for requester i.
- `busy_out` out 1: high while any read in flight.
- `conflict_count_out` out 16: see Configuration.

## Operation
- Eligible(i) = `req_in[i]` && !`pending[i]`. `pending[i]` is set on grant to i and cleared on the cycle `data_valid_out[i]` is driven.
- At most one outstanding read per requester. A requester holding `req_in` through its ack cycle is not regranted.
- Round-robin pointer `ptr` resets to 0.
  - Each cycle, search eligible requesters from `ptr` upward modulo `NUM_REQ`; the first hit w wins.
  - On a grant, register `map_addra_out <= addr[w]`, `ack_out[w] <= 1`, `pending[w] <= 1`, `ptr <= (w+1) mod NUM_REQ`.
  - With no eligible requester: `ack_out <= 0`, and `map_addra_out` and `ptr` hold.
- Tag pipeline has `READ_LATENCY+1` stages of {valid, owner index}.
  - Stage 0 is loaded on grant and advances every cycle, with no stall.
  - When the last stage is valid, register `data_out <= map_data_in`, `data_valid_out[owner] <= 1`, and clear `pending[owner]`.
- Same-cycle clear and eligibility: a requester receiving `data_valid_out` may already have `req_in` high that cycle and is eligible that same cycle. This gives back-to-back reuse.
- `busy_out` = OR of tag-pipeline valids.
- Reset (`rst_in` low, any time, asynchronous) clears:
  - `ack_out`, `data_valid_out`, `pending`, and all tag valids;
  - `ptr`, `map_addra_out`, `data_out`, `busy_out`, and `conflict_count_out` to 0.
- In-flight reads are discarded. No `data_valid_out` is produced for reads granted before reset, even though the BRAM still returns data.

## Timing
- Request high at edge t with requester eligible and winning: `ack_out` is high during cycle t+1, and `map_addra_out` is valid during t+1.
- `map_data_in` is sampled at edge t+1+`READ_LATENCY`. `data_valid_out`/`data_out` are high during cycle t+2+`READ_LATENCY`; this is 4 cycles after the request edge at default latency.
- Throughput: one grant per cycle when distinct requesters are eligible. A single requester can be granted at most once per `READ_LATENCY+2` cycles.
- All outputs are registered except `busy_out`, which is a combinational OR of registers.

## Configuration
- `MAP_ARB_STATS_EN` defined: `conflict_count_out` is a 16-bit counter.
  - Increments by 1 each cycle with two or more eligible requesters.
  - Saturates at 16'hFFFF and is cleared only by reset.
- Not defined: `conflict_count_out` is constant 0 and no counter logic is synthesized.
- Arbitration behavior is identical in both cases.

## Test plan
- Single request: `req_in`=4'b0001, `addr_in[0]`=37, BRAM entry 37 = 5'd9 -> `ack_out[0]` at t+1, `map_addra_out`=37, `data_valid_out`=4'b0001 with `data_out`=9 at t+4 (`READ_LATENCY`=2).
- All four requesting continuously from reset -> grants 0,1,2,3 on consecutive cycles, then requester 0 is regranted on the cycle its data returns. Every `data_valid_out` owner and value matches its own address.
- Held request: requester 2 keeps `req_in` high for 10 cycles -> exactly one ack per `READ_LATENCY+2` cycles, never two reads outstanding.
- Fairness: requesters 1 and 3 both continuously requesting -> ack order alternates 1,3,1,3. With `MAP_ARB_STATS_EN` defined, `conflict_count_out` increases on each cycle where both requesters are eligible.
- Reset mid-flight: assert `rst_in` low one cycle after ack to requester 1 -> all outputs 0 immediately. No `data_valid_out` follows after release; `busy_out`=0.
- Saturation (`MAP_ARB_STATS_EN` defined, counter preloaded near max via force) -> `conflict_count_out` holds at 16'hFFFF.
